// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the move detector: FSM state codes, default debounce
// length and a one-hot helper used when multi-key rejection is compiled in.
package detector_jogada_pkg;

  // State codes are what the 7-segment debug display shows.
  typedef enum logic [3:0] {
    ESPERA  = 4'd0,
    FILTRA  = 4'd1,
    CAPTURA = 4'd2,
    SOLTURA = 4'd3
  } estado_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // True when exactly one bit of the word is set.
  function automatic logic is_onehot(input logic [31:0] v);
    return ($countones(v) == 32'd1);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for the raw key bus. Synchronous active-high reset.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous keys into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/detector_jogada.sv
// Move detector: synchronizes and debounces the key bus, captures the stable
// key code and emits one single-cycle jogada pulse per press, then waits for a
// debounced release before accepting another press.
// Optional build macro DETECTOR_JOGADA_ONEHOT_EN: stable codes that are not
// one-hot are rejected (db_invalida pulses, no jogada). Without it any nonzero
// stable code is captured and db_invalida is tied low.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] chaves,
  input  logic             habilita,
  output logic             jogada,
  output logic [WIDTH-1:0] jogada_valor,
  output logic             db_estavel,
  output logic             db_invalida,
  output logic [3:0]       db_estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [WIDTH-1:0] KEYS_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] chaves_s;
  estado_t          estado_r, estado_next_s;
  logic [WIDTH-1:0] amostra_r, amostra_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             jogada_r;
  logic [WIDTH-1:0] valor_r;
  logic             estavel_r;
`ifdef DETECTOR_JOGADA_ONEHOT_EN
  logic             invalida_next_s;
  logic             invalida_r;
`endif

  sincronizador_2ff #(.WIDTH(WIDTH)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (chaves),
    .q     (chaves_s)
  );

  // Next-state, sample and debounce-counter computation.
  always_comb begin
    estado_next_s  = estado_r;
    amostra_next_s = amostra_r;
    cnt_next_s     = cnt_r;
`ifdef DETECTOR_JOGADA_ONEHOT_EN
    invalida_next_s = 1'b0;
`endif
    case (estado_r)
      ESPERA: begin
        cnt_next_s = CNT_ZERO;
        if (habilita && (chaves_s != KEYS_ZERO)) begin
          estado_next_s  = FILTRA;
          amostra_next_s = chaves_s;
        end else begin
          estado_next_s = ESPERA;
        end
      end
      FILTRA: begin
        if (!habilita || (chaves_s == KEYS_ZERO)) begin
          estado_next_s = ESPERA;
          cnt_next_s    = CNT_ZERO;
        end else if (chaves_s != amostra_r) begin
          // A different key code restarts the filter on the new code.
          amostra_next_s = chaves_s;
          cnt_next_s     = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          cnt_next_s = CNT_ZERO;
`ifdef DETECTOR_JOGADA_ONEHOT_EN
          if (!is_onehot(32'(amostra_r))) begin
            estado_next_s   = SOLTURA;
            invalida_next_s = 1'b1;
          end else begin
            estado_next_s = CAPTURA;
          end
`else
          estado_next_s = CAPTURA;
`endif
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      CAPTURA: begin
        // The pulse is already committed; habilita no longer matters.
        estado_next_s = SOLTURA;
        cnt_next_s    = CNT_ZERO;
      end
      SOLTURA: begin
        if (chaves_s != KEYS_ZERO) begin
          cnt_next_s = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          estado_next_s = ESPERA;
          cnt_next_s    = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        estado_next_s = ESPERA;
        cnt_next_s    = CNT_ZERO;
      end
    endcase
  end

  // FSM state, sample and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r  <= ESPERA;
      amostra_r <= KEYS_ZERO;
      cnt_r     <= CNT_ZERO;
    end else begin
      estado_r  <= estado_next_s;
      amostra_r <= amostra_next_s;
      cnt_r     <= cnt_next_s;
    end
  end

  // Output registers, loaded from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      jogada_r  <= 1'b0;
      valor_r   <= KEYS_ZERO;
      estavel_r <= 1'b0;
    end else begin
      jogada_r  <= (estado_next_s == CAPTURA);
      estavel_r <= (estado_next_s == FILTRA);
      if (estado_next_s == CAPTURA) begin
        valor_r <= amostra_r;
      end else begin
        valor_r <= valor_r;
      end
    end
  end

`ifdef DETECTOR_JOGADA_ONEHOT_EN
  // Single-cycle flag for a rejected multi-key press.
  always_ff @(posedge clock) begin
    if (reset) begin
      invalida_r <= 1'b0;
    end else begin
      invalida_r <= invalida_next_s;
    end
  end
  assign db_invalida = invalida_r;
`else
  assign db_invalida = 1'b0;
`endif

  assign jogada       = jogada_r;
  assign jogada_valor = valor_r;
  assign db_estavel   = estavel_r;
  assign db_estado    = estado_r;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed self-checking bench for detector_jogada (DEBOUNCE_CYCLES = 4).
module tb_detector_jogada;
  import detector_jogada_pkg::*;

  logic       clock;
  logic       reset;
  logic [3:0] chaves;
  logic       habilita;
  logic       jogada;
  logic [3:0] jogada_valor;
  logic       db_estavel;
  logic       db_invalida;
  logic [3:0] db_estado;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses, first, inv, pulses2, first2, inv2;

  detector_jogada #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .chaves       (chaves),
    .habilita     (habilita),
    .jogada       (jogada),
    .jogada_valor (jogada_valor),
    .db_estavel   (db_estavel),
    .db_invalida  (db_invalida),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run n cycles, counting jogada / db_invalida pulses and the first jogada tick.
  task automatic run(input int n, output int p, output int f, output int iv);
    p = 0; f = 0; iv = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (jogada === 1'b1) begin
        p++;
        if (f == 0) f = i;
      end
      if (db_invalida === 1'b1) iv++;
    end
  endtask

  initial begin
    reset = 1'b1; chaves = 4'b0100; habilita = 1'b1;
    // Reset held two cycles with a key pressed
    tick(); tick();
    check("rst_estado", 32'(db_estado), 32'd0);
    check("rst_jogada", 32'(jogada), 32'd0);
    check("rst_valor", 32'(jogada_valor), 32'd0);
    check("rst_estavel", 32'(db_estavel), 32'd0);
    check("rst_invalida", 32'(db_invalida), 32'd0);
    reset = 1'b0; chaves = 4'b0000;
    run(6, pulses, first, inv);
    check("post_rst_pulses", 32'(pulses), 32'd0);

    // Clean press: first sampling edge is tick 1, pulse visible after tick 7
    chaves = 4'b0010;
    run(3, pulses, first, inv);
    check("clean_filtra", 32'(db_estado), 32'd1);
    check("clean_estavel", 32'(db_estavel), 32'd1);
    run(7, pulses2, first2, inv2);
    check("clean_pulses", 32'(pulses + pulses2), 32'd1);
    check("clean_latency", 32'(first2), 32'd4);
    chaves = 4'b0000;
    run(10, pulses, first, inv);
    check("clean_rel_pulses", 32'(pulses), 32'd0);
    check("clean_valor", 32'(jogada_valor), 32'h2);
    check("clean_rel_estado", 32'(db_estado), 32'd0);

    // Bounce on press and on release
    pulses2 = 0;
    for (int k = 0; k < 3; k++) begin
      chaves = 4'b0001; run(2, pulses, first, inv); pulses2 += pulses;
      chaves = 4'b0000; run(2, pulses, first, inv); pulses2 += pulses;
    end
    check("bounce_glitch_pulses", 32'(pulses2), 32'd0);
    chaves = 4'b0001; run(8, pulses, first, inv); pulses2 += pulses;
    for (int k = 0; k < 2; k++) begin
      chaves = 4'b0000; run(2, pulses, first, inv); pulses2 += pulses;
      chaves = 4'b0001; run(2, pulses, first, inv); pulses2 += pulses;
    end
    chaves = 4'b0000; run(10, pulses, first, inv); pulses2 += pulses;
    check("bounce_pulses", 32'(pulses2), 32'd1);
    check("bounce_valor", 32'(jogada_valor), 32'h1);
    check("bounce_estado", 32'(db_estado), 32'd0);

    // Disabled press, then enable while held
    habilita = 1'b0; chaves = 4'b1000;
    run(10, pulses, first, inv);
    check("dis_pulses", 32'(pulses), 32'd0);
    check("dis_estado", 32'(db_estado), 32'd0);
    habilita = 1'b1;
    run(10, pulses, first, inv);
    check("en_pulses", 32'(pulses), 32'd1);
    check("en_latency", 32'(first), 32'd5);
    check("en_valor", 32'(jogada_valor), 32'h8);
    chaves = 4'b0000;
    run(10, pulses, first, inv);
    check("en_rel_pulses", 32'(pulses), 32'd0);

    // Code change in the middle of filtering
    chaves = 4'b0001; run(2, pulses, first, inv);
    chaves = 4'b0100; run(10, pulses2, first2, inv2);
    check("chg_pulses", 32'(pulses + pulses2), 32'd1);
    check("chg_valor", 32'(jogada_valor), 32'h4);
    chaves = 4'b0000; run(10, pulses, first, inv);
    check("chg_rel_estado", 32'(db_estado), 32'd0);

    // Multi-key stable code
    chaves = 4'b0110; run(10, pulses, first, inv);
`ifdef DETECTOR_JOGADA_ONEHOT_EN
    check("multi_pulses", 32'(pulses), 32'd0);
    check("multi_invalida", 32'(inv), 32'd1);
    check("multi_estado", 32'(db_estado), 32'd3);
    check("multi_valor", 32'(jogada_valor), 32'h4);
`else
    check("multi_pulses", 32'(pulses), 32'd1);
    check("multi_invalida", 32'(inv), 32'd0);
    check("multi_valor", 32'(jogada_valor), 32'h6);
    check("multi_estado", 32'(db_estado), 32'd3);
`endif
    chaves = 4'b0000; run(10, pulses, first, inv);
    check("multi_rel_estado", 32'(db_estado), 32'd0);

    // Reset in mid-press aborts without a pulse
    chaves = 4'b0010; run(4, pulses, first, inv);
    reset = 1'b1; run(1, pulses2, first2, inv2); pulses += pulses2;
    reset = 1'b0; chaves = 4'b0000; run(8, pulses2, first2, inv2); pulses += pulses2;
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_estado", 32'(db_estado), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
